// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load, five shift/rotate modes with carry-out,
// and a built-in sequencer that runs a programmed number of steps after one start strobe.
module universal_shift_register #(
    parameter int WORD_LENGTH = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] D,
    input  logic                   load,
    input  logic                   shift,
    input  logic                   start,
    input  logic [2:0]             mode,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic                   serial_in,
    output logic [WORD_LENGTH-1:0] Q,
    output logic                   carry_out,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [2:0] MODE_SHL  = 3'd0;
    localparam logic [2:0] MODE_SHR  = 3'd1;
    localparam logic [2:0] MODE_ASR  = 3'd2;
    localparam logic [2:0] MODE_ROL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;

    state_t                   state, state_next;
    logic [2:0]               mode_r, mode_r_next, step_mode;
    logic [COUNT_WIDTH-1:0]   remaining, remaining_next;
    logic [WORD_LENGTH-1:0]   q_next, step_q;
    logic                     carry_next, step_carry;
    logic                     busy_next, done_next;

    // A run uses the mode captured at start; single steps in IDLE use the live input.
    assign step_mode = (state == RUN) ? mode_r : mode;

    // One shift step; reserved modes leave both Q and carry_out untouched.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        step_q     = Q;
        step_carry = carry_out;
        case (step_mode)
            MODE_SHL: begin
                step_q     = {Q[WORD_LENGTH-2:0], serial_in};
                step_carry = Q[WORD_LENGTH-1];
            end
            MODE_SHR: begin
                step_q     = {serial_in, Q[WORD_LENGTH-1:1]};
                step_carry = Q[0];
            end
            MODE_ASR: begin
                step_q     = {Q[WORD_LENGTH-1], Q[WORD_LENGTH-1:1]};
                step_carry = Q[0];
            end
            MODE_ROL: begin
                step_q     = {Q[WORD_LENGTH-2:0], Q[WORD_LENGTH-1]};
                step_carry = Q[WORD_LENGTH-1];
            end
            MODE_ROR: begin
                step_q     = {Q[0], Q[WORD_LENGTH-1:1]};
                step_carry = Q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next     = state;
        q_next         = Q;
        carry_next     = carry_out;
        mode_r_next    = mode_r;
        remaining_next = remaining;
        busy_next      = busy;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    q_next = D;
                end else if (start) begin
                    if (count != '0) begin
                        mode_r_next    = mode;
                        remaining_next = count;
                        busy_next      = 1'b1;
                        state_next     = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end else if (shift) begin
                    q_next     = step_q;
                    carry_next = step_carry;
                end
            end
            RUN: begin
                // Control inputs are deliberately ignored until the run finishes.
                q_next         = step_q;
                carry_next     = step_carry;
                remaining_next = remaining - COUNT_WIDTH'(1);
                if (remaining == COUNT_WIDTH'(1)) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            Q         <= '0;
            carry_out <= 1'b0;
            mode_r    <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            Q         <= q_next;
            carry_out <= carry_next;
            mode_r    <= mode_r_next;
            remaining <= remaining_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: idle single-step vectors from a table,
// auto runs checked through an expected-result queue popped on the done pulse.
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  D;
    logic          load, shift, start;
    logic [2:0]    mode;
    logic [CW-1:0] count;
    logic          serial_in;
    logic [W-1:0]  Q;
    logic          carry_out, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         load, shift, start;
        logic [W-1:0] d;
        logic [2:0]   mode;
        logic [CW-1:0] count;
        logic         sin;
        logic [W-1:0] exp_q;
        logic         exp_c, exp_busy, exp_done;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic         c;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic cur_c;

    universal_shift_register #(.WORD_LENGTH(W), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .D(D), .load(load), .shift(shift), .start(start),
        .mode(mode), .count(count), .serial_in(serial_in), .Q(Q),
        .carry_out(carry_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic ld, logic sh, logic st, logic [W-1:0] d, logic [2:0] m,
                                logic [CW-1:0] n, logic sin, logic [W-1:0] eq, logic ec,
                                logic eb, logic ed);
        vec_t v;
        v.load = ld; v.shift = sh; v.start = st; v.d = d; v.mode = m; v.count = n;
        v.sin = sin; v.exp_q = eq; v.exp_c = ec; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    // Bit-level reference of an N-step run.
    function automatic exp_t model(logic [W-1:0] q0, logic c0, logic [2:0] m, int n, logic sin);
        exp_t r;
        logic [W-1:0] t;
        r.q = q0;
        r.c = c0;
        for (int k = 0; k < n; k++) begin
            t = r.q;
            case (m)
                3'd0: begin r.c = t[W-1]; for (int b = W-1; b > 0; b--) r.q[b] = t[b-1]; r.q[0] = sin; end
                3'd1: begin r.c = t[0]; for (int b = 0; b < W-1; b++) r.q[b] = t[b+1]; r.q[W-1] = sin; end
                3'd2: begin r.c = t[0]; for (int b = 0; b < W-1; b++) r.q[b] = t[b+1]; r.q[W-1] = t[W-1]; end
                3'd3: begin r.c = t[W-1]; r.q = (t << 1) | (t >> (W-1)); end
                3'd4: begin r.c = t[0]; r.q = (t >> 1) | (t << (W-1)); end
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic do_load(input logic [W-1:0] d);
        D = d; load = 1'b1;
        tick();
        load = 1'b0;
        check("load_q", Q, d);
    endtask

    task automatic run_auto(input logic [2:0] m, input logic [CW-1:0] n, input logic [W-1:0] eq,
                            input logic ec, input bit disturb);
        exp_t e;
        int   busy_cycles;
        int   cyc;
        e.q = eq;
        e.c = ec;
        sb.push_back(e);
        mode = m; count = n; start = 1'b1;
        tick();
        start = 1'b0;
        check("done_low_after_start", done, 1'b0);
        busy_cycles = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 64) begin
            if (busy === 1'b1) busy_cycles++;
            if (disturb && cyc == 1) begin
                load = 1'b1; start = 1'b1; shift = 1'b1; D = 8'hFF; mode = ~m; count = 4'd9;
            end else begin
                load = 1'b0; start = 1'b0; shift = 1'b0;
            end
            tick();
            cyc++;
        end
        load = 1'b0; start = 1'b0; shift = 1'b0;
        check("run_done_seen", done, 1'b1);
        check("run_busy_cycles", busy_cycles, n);
        check("run_busy_low_at_done", busy, 1'b0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("run_q", Q, e.q);
            check("run_carry", carry_out, e.c);
        end else begin
            check("scoreboard_empty", 1'b1, 1'b0);
        end
    endtask

    initial begin
        exp_t          r;
        logic [2:0]    rm;
        logic [CW-1:0] rn;
        logic          rs;
        logic [W-1:0]  rd;

        // Idle single-cycle vectors: load > start > shift priority, every mode, count==0 start.
        vecs.push_back(mk(0,0,0, 8'h00, 3'd0, 4'd0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1,0,0, 8'hB4, 3'd0, 4'd0, 0, 8'hB4, 0, 0, 0));
        vecs.push_back(mk(0,1,0, 8'h00, 3'd0, 4'd0, 1, 8'h69, 1, 0, 0));
        vecs.push_back(mk(0,1,0, 8'h00, 3'd1, 4'd0, 0, 8'h34, 1, 0, 0));
        vecs.push_back(mk(0,1,0, 8'h00, 3'd2, 4'd0, 0, 8'h1A, 0, 0, 0));
        vecs.push_back(mk(1,0,0, 8'h81, 3'd0, 4'd0, 0, 8'h81, 0, 0, 0));
        vecs.push_back(mk(0,1,0, 8'h00, 3'd2, 4'd0, 0, 8'hC0, 1, 0, 0));
        vecs.push_back(mk(0,1,0, 8'h00, 3'd3, 4'd0, 0, 8'h81, 1, 0, 0));
        vecs.push_back(mk(0,1,0, 8'h00, 3'd4, 4'd0, 0, 8'hC0, 1, 0, 0));
        vecs.push_back(mk(0,1,0, 8'h00, 3'd5, 4'd0, 0, 8'hC0, 1, 0, 0));
        vecs.push_back(mk(0,1,0, 8'h00, 3'd4, 4'd0, 0, 8'h60, 0, 0, 0));
        vecs.push_back(mk(0,1,0, 8'h00, 3'd6, 4'd0, 1, 8'h60, 0, 0, 0));
        vecs.push_back(mk(1,1,0, 8'h5A, 3'd0, 4'd0, 1, 8'h5A, 0, 0, 0));
        vecs.push_back(mk(0,1,1, 8'h00, 3'd0, 4'd0, 1, 8'h5A, 0, 0, 1));
        vecs.push_back(mk(0,0,0, 8'h00, 3'd0, 4'd0, 0, 8'h5A, 0, 0, 0));
        vecs.push_back(mk(1,0,1, 8'h3C, 3'd0, 4'd3, 0, 8'h3C, 0, 0, 0));
        vecs.push_back(mk(0,0,0, 8'h00, 3'd0, 4'd0, 0, 8'h3C, 0, 0, 0));

        D = '0; load = 0; shift = 0; start = 0; mode = '0; count = '0; serial_in = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("reset_q", Q, 8'h00);
        check("reset_carry", carry_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        #9 reset = 1'b1;
        tick();

        foreach (vecs[i]) begin
            load = vecs[i].load; shift = vecs[i].shift; start = vecs[i].start;
            D = vecs[i].d; mode = vecs[i].mode; count = vecs[i].count; serial_in = vecs[i].sin;
            tick();
            load = 0; shift = 0; start = 0;
            check($sformatf("vec%0d_q", i), Q, vecs[i].exp_q);
            check($sformatf("vec%0d_carry", i), carry_out, vecs[i].exp_c);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
        end

        // Arithmetic right run.
        do_load(8'hB4);
        run_auto(3'd2, 4'd3, 8'hF6, 1'b1, 1'b0);

        // Rotates, including a full-width rotate right.
        do_load(8'h81);
        run_auto(3'd3, 4'd1, 8'h03, 1'b1, 1'b0);
        do_load(8'h01);
        run_auto(3'd4, 4'd8, 8'h01, 1'b0, 1'b0);

        // Serial fill, then a single idle step.
        do_load(8'h00);
        serial_in = 1'b1;
        run_auto(3'd0, 4'd4, 8'h0F, 1'b0, 1'b0);
        mode = 3'd1; serial_in = 1'b0; shift = 1'b1;
        tick();
        shift = 1'b0;
        check("idle_shift_q", Q, 8'h07);
        check("idle_shift_carry", carry_out, 1'b1);
        check("idle_shift_done", done, 1'b0);

        // Inputs ignored mid-run, then a back-to-back reserved-mode run.
        do_load(8'h96);
        serial_in = 1'b0;
        run_auto(3'd1, 4'd5, 8'h04, 1'b1, 1'b1);
        run_auto(3'd5, 4'd2, 8'h04, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a run.
        do_load(8'hA5);
        mode = 3'd0; count = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midrun_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_q", Q, 8'h00);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_done", done, 1'b0);
        check("async_reset_carry", carry_out, 1'b0);
        #2 reset = 1'b1;
        tick();
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_q", Q, 8'h00);
        do_load(8'hA5);
        run_auto(3'd3, 4'd2, 8'h96, 1'b0, 1'b0);
        cur_c = 1'b0;

        // Model-checked runs with random modes, counts and fill bits.
        for (int k = 0; k < 8; k++) begin
            rm = 3'($urandom_range(0, 7));
            rn = CW'($urandom_range(1, 15));
            rs = 1'($urandom_range(0, 1));
            rd = W'($urandom_range(0, 255));
            do_load(rd);
            r = model(rd, cur_c, rm, int'(rn), rs);
            serial_in = rs;
            run_auto(rm, rn, r.q, r.c, 1'b0);
            cur_c = r.c;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
